// File: rtl/debug_loader_pkg.sv
// Shared types and constants for the program-load debug initiator.
package debug_loader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_LEN   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_CSUM  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ADDR  = ST_ADDR,
        S_LEN   = ST_LEN,
        S_DATA  = ST_DATA,
        S_WRITE = ST_WRITE,
        S_CSUM  = ST_CSUM,
        S_DONE  = ST_DONE
    } state_e;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam int unsigned BASE_BYTES    = 4;
    localparam int unsigned LEN_BYTES     = 2;
    localparam int unsigned WORD_BYTES    = 4;
    localparam int unsigned CSUM_BYTES    = 1;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/dbg_word_assembler.sv
// Little-endian byte-to-word assembler shared by the BASE and DATA fields.
module dbg_word_assembler
    import debug_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {byte_i, word_q[31:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    // Word includes the byte accepted this cycle so the caller can act on it immediately.
    assign word_o      = word_d;
    assign word_full_o = shift_i && !clr_i && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/debug_loader.sv
// Framed byte stream -> instruction-memory write initiator for the core debug port.
// Optional trailing XOR checksum byte enabled by defining CHECKSUM_EN.
module debug_loader
    import debug_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        debug_sig,
    output logic [31:0] debug_addr,
    output logic [31:0] debug_instr,
    output logic        debug_we,
    output logic        load_done,
    output logic        err,
    output logic        busy
);

`ifdef CHECKSUM_EN
    localparam state_e S_TAIL = S_CSUM;
`else
    localparam state_e S_TAIL = S_DONE;
`endif
    localparam logic LEN_LAST = 1'(LEN_BYTES - 1);

    state_e      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic        len_cnt_q, len_cnt_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        err_q, err_d;
`ifdef CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        accept;
    logic        asm_clr;
    logic [31:0] asm_word;
    logic        asm_full;
    logic [15:0] len_next;

    assign accept   = rx_valid && rx_ready;
    assign asm_clr  = !(state_q == S_ADDR || state_q == S_DATA);
    assign len_next = {rx_data, len_q[15:8]};

    dbg_word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (asm_clr),
        .shift_i     (accept),
        .byte_i      (rx_data),
        .word_o      (asm_word),
        .word_full_o (asm_full)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        len_d     = len_q;
        idx_d     = idx_q;
        len_cnt_d = len_cnt_q;
        err_d     = err_q;
        to_cnt_d  = '0;
`ifdef CHECKSUM_EN
        csum_d    = csum_q;
        if (accept && state_q != S_IDLE) csum_d = csum_q ^ rx_data;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d   = S_ADDR;
                    err_d     = 1'b0;
                    len_cnt_d = 1'b0;
`ifdef CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            S_ADDR: begin
                if (asm_full) begin
                    if (asm_word[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        base_d  = asm_word;
                        state_d = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d     = len_next;
                    len_cnt_d = len_cnt_q + 1'b1;
                    if (len_cnt_q == LEN_LAST) begin
                        idx_d   = '0;
                        state_d = (len_next == '0) ? S_TAIL : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (asm_full) begin
                    instr_d = asm_word;
                    addr_d  = word_addr(base_q, idx_q);
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + 16'd1;
                state_d = (idx_q == len_q - 16'd1) ? S_TAIL : S_DATA;
            end
            S_CSUM: begin
`ifdef CHECKSUM_EN
                if (accept) begin
                    if (rx_data != csum_q) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Idle-gap watchdog; abort overrides whatever the field logic chose.
        if ((state_q == S_ADDR || state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM)
            && !accept) begin
            if (to_cnt_q == TIMEOUT_CYC - 1) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            instr_q   <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            len_cnt_q <= 1'b0;
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            len_cnt_q <= len_cnt_d;
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
`ifdef CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign rx_ready    = !(state_q == S_WRITE || state_q == S_DONE);
    assign debug_sig   = (state_q != S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign debug_we    = (state_q == S_WRITE);
    assign load_done   = (state_q == S_DONE);
    assign debug_addr  = addr_q;
    assign debug_instr = instr_q;
    assign err         = err_q;

endmodule

// File: tb/tb_debug_loader.sv
// Directed bench for debug_loader; define CHECKSUM_EN to also exercise the trailing checksum.
module tb_debug_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        debug_sig;
    logic [31:0] debug_addr;
    logic [31:0] debug_instr;
    logic        debug_we;
    logic        load_done;
    logic        err;
    logic        busy;

    debug_loader #(.TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .debug_sig   (debug_sig),
        .debug_addr  (debug_addr),
        .debug_instr (debug_instr),
        .debug_we    (debug_we),
        .load_done   (load_done),
        .err         (err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write/done monitor sampled on the falling edge.
    logic [31:0] we_addr[$];
    logic [31:0] we_instr[$];
    logic        we_rdy[$];
    int unsigned done_cnt = 0;

    always @(negedge clk) begin
        if (debug_we) begin
            we_addr.push_back(debug_addr);
            we_instr.push_back(debug_instr);
            we_rdy.push_back(rx_ready);
        end
        if (load_done) done_cnt++;
    end

    logic [31:0] frame_words[$];
`ifdef CHECKSUM_EN
    logic [7:0]  csum_flip = 8'h00;
`endif

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int unsigned n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check_eq("rx_ready_wait", {31'b0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, inout logic [7:0] cs);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b  = w[8*i +: 8];
            cs = cs ^ b;
            send_byte(b);
        end
    endtask

    task automatic send_frame(input logic [31:0] base);
        logic [7:0]  cs;
        logic [15:0] len;
        cs  = '0;
        len = 16'(frame_words.size());
        send_byte(8'hA5);
        send_word(base, cs);
        cs = cs ^ len[7:0] ^ len[15:8];
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        for (int i = 0; i < int'(len); i++) send_word(frame_words[i], cs);
`ifdef CHECKSUM_EN
        send_byte(cs ^ csum_flip);
`endif
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    int unsigned we0;
    int unsigned dn0;

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        idle(3);
        rst = 1'b0;
        idle(1);

        check_eq("rst_sig",   {31'b0, debug_sig}, 32'd0);
        check_eq("rst_addr",  debug_addr,          32'd0);
        check_eq("rst_instr", debug_instr,         32'd0);
        check_eq("rst_we",    {31'b0, debug_we},  32'd0);
        check_eq("rst_done",  {31'b0, load_done}, 32'd0);
        check_eq("rst_err",   {31'b0, err},       32'd0);
        check_eq("rst_ready", {31'b0, rx_ready},  32'd1);
        check_eq("rst_busy",  {31'b0, busy},      32'd0);

        // Two-word load at 0x1000
        we0 = we_addr.size(); dn0 = done_cnt;
        frame_words = '{32'h0000_0013, 32'h0010_0093};
        send_byte(8'hA5);
        check_eq("sync_sig", {31'b0, debug_sig}, 32'd1);
        begin
            logic [7:0] cs;
            cs = '0;
            send_word(32'h0000_1000, cs);
            cs = cs ^ 8'h02;
            send_byte(8'h02);
            send_byte(8'h00);
            send_word(frame_words[0], cs);
            send_word(frame_words[1], cs);
`ifdef CHECKSUM_EN
            send_byte(cs);
`endif
        end
        idle(4);
        check_eq("t1_we_cnt", we_addr.size() - we0, 32'd2);
        if (we_addr.size() >= we0 + 2) begin
            check_eq("t1_addr0",  we_addr[we0],      32'h0000_1000);
            check_eq("t1_instr0", we_instr[we0],     32'h0000_0013);
            check_eq("t1_addr1",  we_addr[we0+1],    32'h0000_1004);
            check_eq("t1_instr1", we_instr[we0+1],   32'h0010_0093);
            check_eq("t1_rdy_we", {31'b0, we_rdy[we0]}, 32'd0);
        end
        check_eq("t1_done",       done_cnt - dn0,      32'd1);
        check_eq("t1_sig_after",  {31'b0, debug_sig}, 32'd0);
        check_eq("t1_err",        {31'b0, err},       32'd0);
        check_eq("t1_addr_hold",  debug_addr,          32'h0000_1004);
        check_eq("t1_instr_hold", debug_instr,         32'h0010_0093);

        // Garbage before sync, then empty frame
        we0 = we_addr.size(); dn0 = done_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check_eq("t2_busy_garbage", {31'b0, busy}, 32'd0);
        frame_words = '{};
        send_frame(32'h0000_0000);
        idle(4);
        check_eq("t2_we_cnt", we_addr.size() - we0, 32'd0);
        check_eq("t2_done",   done_cnt - dn0,       32'd1);

        // Misaligned base
        we0 = we_addr.size(); dn0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check_eq("t3_err",  {31'b0, err},  32'd1);
        check_eq("t3_busy", {31'b0, busy}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h00);
        idle(3);
        check_eq("t3_err_sticky", {31'b0, err}, 32'd1);
        check_eq("t3_we_cnt", we_addr.size() - we0, 32'd0);
        check_eq("t3_done",   done_cnt - dn0,       32'd0);
        send_byte(8'hA5);
        check_eq("t3_err_clr", {31'b0, err}, 32'd0);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00);
`ifdef CHECKSUM_EN
        send_byte(8'h01);
`endif
        idle(3);
        check_eq("t3_recover_done", done_cnt - dn0, 32'd1);

        // Timeout after two data bytes
        we0 = we_addr.size(); dn0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        idle(15);
        check_eq("t4_err_15", {31'b0, err},       32'd0);
        check_eq("t4_sig_15", {31'b0, debug_sig}, 32'd1);
        idle(1);
        check_eq("t4_err_16", {31'b0, err},       32'd1);
        check_eq("t4_sig_16", {31'b0, debug_sig}, 32'd0);
        check_eq("t4_we_cnt", we_addr.size() - we0, 32'd0);
        check_eq("t4_done",   done_cnt - dn0,       32'd0);

        // Reset in DATA after first word
        we0 = we_addr.size(); dn0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h00); send_byte(8'h30); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hAA);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_eq("t5_sig",   {31'b0, debug_sig}, 32'd0);
        check_eq("t5_addr",  debug_addr,          32'd0);
        check_eq("t5_instr", debug_instr,         32'd0);
        check_eq("t5_err",   {31'b0, err},       32'd0);
        check_eq("t5_busy",  {31'b0, busy},      32'd0);
        check_eq("t5_ready", {31'b0, rx_ready},  32'd1);
        send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        idle(4);
        check_eq("t5_we_cnt", we_addr.size() - we0, 32'd1);
        if (we_addr.size() > we0) begin
            check_eq("t5_addr0",  we_addr[we0],  32'h0000_3000);
            check_eq("t5_instr0", we_instr[we0], 32'h1234_5678);
        end
        check_eq("t5_done", done_cnt - dn0, 32'd0);

        // Address wrap past 0xFFFFFFFC
        we0 = we_addr.size(); dn0 = done_cnt;
        frame_words = '{32'hAABB_CCDD, 32'h1122_3344};
        send_frame(32'hFFFF_FFFC);
        idle(4);
        check_eq("t6_we_cnt", we_addr.size() - we0, 32'd2);
        if (we_addr.size() >= we0 + 2) begin
            check_eq("t6_addr0",  we_addr[we0],    32'hFFFF_FFFC);
            check_eq("t6_addr1",  we_addr[we0+1],  32'h0000_0000);
            check_eq("t6_instr1", we_instr[we0+1], 32'h1122_3344);
        end
        check_eq("t6_done", done_cnt - dn0, 32'd1);
        check_eq("t6_err",  {31'b0, err},   32'd0);

`ifdef CHECKSUM_EN
        we0 = we_addr.size(); dn0 = done_cnt;
        frame_words = '{32'hDEAD_BEEF};
        csum_flip = 8'h01;
        send_frame(32'h0000_4000);
        idle(4);
        check_eq("cs_bad_we",   we_addr.size() - we0, 32'd1);
        check_eq("cs_bad_err",  {31'b0, err},         32'd1);
        check_eq("cs_bad_done", done_cnt - dn0,       32'd0);
        dn0 = done_cnt;
        csum_flip = 8'h00;
        send_frame(32'h0000_4000);
        idle(4);
        check_eq("cs_ok_done", done_cnt - dn0, 32'd1);
        check_eq("cs_ok_err",  {31'b0, err},   32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
